dot_product_collector: RTL and testbench
========================================

DOT_PRODUCT_COLLECTOR -- requirements
Module: dot_product_collector

Interface
REQ-001 The block SHALL have parameter DW, default 4, operand width.
REQ-002 The block SHALL have parameter RW, default 10, result width, sized as 3*(2^DW-1)^2 = 675 max.
REQ-003 The block SHALL have parameter DEPTH, default 9, result buffer entries.
REQ-004 Clock and reset SHALL be: clk, in, 1, rising-edge clock; rst_n, in, 1, reset (one clock; reset is asynchronous and active-low).
REQ-005 The block SHALL have these ports:
- start, in, 1, one-cycle job start pulse.
- row_w, in, 2, rows of W, sampled on start.
- col_x, in, 2, columns of X, sampled on start.
- in_valid, in, 1, driven by the memory bank's ld_mac: lane operands valid.
- in_w1/in_w2/in_w3, in, DW each, W row lanes.
- in_x1/in_x2/in_x3, in, DW each, X column lanes.
- res_data, out, RW, result element.
- res_idx, out, 4, row-major element index.
- res_valid, out, 1, result offered.
- res_ready, in, 1, consumer accepts.
- busy, out, 1, job in progress.
- done, out, 1, one-cycle job-complete pulse.
- err, out, 1, sticky protocol error.

Function
REQ-006 Element count N SHALL be row_w*col_x, computed unsigned (0..9) and latched on an accepted start.
REQ-007 The FSM SHALL have four states: IDLE, CAPTURE, DRAIN and DONE.
REQ-008 In IDLE, a start with N!=0 SHALL move the FSM to CAPTURE and clear wr_ptr and rd_ptr.
REQ-009 In IDLE, a start with N==0 SHALL move the FSM directly to DONE.
REQ-010 In CAPTURE, each in_valid cycle SHALL compute in_w1*in_x1 + in_w2*in_x2 + in_w3*in_x3, zero-extended to RW with no truncation.
REQ-011 That result SHALL be written to buf[wr_ptr] on the same edge, and wr_ptr SHALL increment.
REQ-012 Lanes carrying 0 SHALL contribute 0, so 1- and 2-term dot products need no special handling.
REQ-013 When the write at wr_ptr==N-1 occurs, the FSM SHALL move to DRAIN on that edge.
REQ-014 In DRAIN, res_valid SHALL be 1, res_data SHALL equal buf[rd_ptr] and res_idx SHALL equal rd_ptr.
REQ-015 In DRAIN, res_data and res_idx SHALL remain stable while res_valid&&!res_ready.
REQ-016 Each res_valid&&res_ready cycle SHALL increment rd_ptr.
REQ-017 The transfer at rd_ptr==N-1 SHALL move the FSM to DONE.
REQ-018 DONE SHALL last one cycle with done=1, then return to IDLE.
REQ-019 busy SHALL be 1 in CAPTURE and DRAIN, and 0 otherwise.
REQ-020 start while busy SHALL be ignored and SHALL set err.
REQ-021 in_valid in DRAIN SHALL be ignored and SHALL set err.
REQ-022 in_valid in IDLE or DONE SHALL be ignored and SHALL NOT set err.
REQ-023 err SHALL clear only on reset or on an accepted start.
REQ-024 The minimum latency SHALL be: the last in_valid edge, then res_valid is visible the following cycle.
REQ-025 With res_ready held at 1, the block SHALL complete N transfers in N cycles, followed by done the next cycle.
REQ-026 Pointers SHALL never exceed N-1, and no wrap-around SHALL occur within a job.

Reset
REQ-027 Asserting rst_n low SHALL asynchronously force IDLE, wr_ptr=rd_ptr=0, N=0, and all buf entries to 0.
REQ-028 During reset, outputs SHALL be res_data=0, res_idx=0, res_valid=0, busy=0, done=0 and err=0.
REQ-029 Reset mid-job SHALL abandon the job, and no partial results SHALL be emitted after release.
REQ-030 The first accepted start SHALL be possible on the first rising edge after rst_n deasserts.

Structure
REQ-031 A shared package SHALL hold DW, RW, DEPTH and the FSM state enum (IDLE, CAPTURE, DRAIN, DONE).
REQ-032 The three-lane multiply-add SHALL be one combinational sub-module, dot3_unit, inputs 3x2 DW-bit lanes, output RW-bit.
REQ-033 The buffer and FSM SHALL remain in dot_product_collector.

Verification
REQ-034 The bench SHALL cover single element: start with row_w=1, col_x=1, then one in_valid with all lanes 15 -> res_data=675, res_idx=0, then done one cycle after the transfer.
REQ-035 The bench SHALL cover a 2x2 job: start with row_w=2, col_x=2, then 4 in_valid cycles with lanes (w1,w2,x1,x2) = (1,2,5,7), (1,2,6,8), (3,4,5,7), (3,4,6,8) and w3=x3=0 -> outputs 19, 22, 43, 50 at idx 0..3.
REQ-036 The bench SHALL cover backpressure: in the 2x2 job, hold res_ready=0 for 3 cycles at idx 1 -> res_data=22 stable, then idx 2 follows the release.
REQ-037 The bench SHALL cover the degenerate job: start with row_w=0 -> done the next cycle, no res_valid, and busy never asserted.
REQ-038 The bench SHALL cover protocol errors: start in CAPTURE -> err=1 and the job continues, then in_valid in DRAIN -> no change to res_data.
REQ-039 The bench SHALL cover reset mid-DRAIN: rst_n low at idx 1 -> all outputs 0 immediately, then a fresh 1x1 job completes correctly.

Source files
------------

// File: rtl/dot_product_collector_pkg.sv
// Shared sizing constants and FSM state encoding for the dot-product collector.
package dot_product_collector_pkg;

  // Operand width of each W / X lane.
  localparam int DW    = 4;
  // Result width: three full-scale products summed, 3*(2^4-1)^2 = 675, fits in 10 bits.
  localparam int RW    = 10;
  // Result buffer entries: up to a 3x3 result matrix.
  localparam int DEPTH = 9;
  // Width of element counts, pointers and the result index.
  localparam int IW    = 4;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    DRAIN   = 2'd2,
    DONE    = 2'd3
  } state_t;

endpackage

// File: rtl/dot_product_collector_dot3.sv
// Three-lane multiply-add: w1*x1 + w2*x2 + w3*x3, widened to RW bits before
// the arithmetic so no intermediate product or sum is truncated.
module dot3_unit #(
  parameter int DW = dot_product_collector_pkg::DW,
  parameter int RW = dot_product_collector_pkg::RW
) (
  input  logic [DW-1:0] i_w1,
  input  logic [DW-1:0] i_w2,
  input  logic [DW-1:0] i_w3,
  input  logic [DW-1:0] i_x1,
  input  logic [DW-1:0] i_x2,
  input  logic [DW-1:0] i_x3,
  output logic [RW-1:0] o_dot
);

  logic [RW-1:0] w_p1;
  logic [RW-1:0] w_p2;
  logic [RW-1:0] w_p3;

  // A lane carrying zero contributes nothing, so short dot products need no masking.
  assign w_p1  = RW'(i_w1) * RW'(i_x1);
  assign w_p2  = RW'(i_w2) * RW'(i_x2);
  assign w_p3  = RW'(i_w3) * RW'(i_x3);
  assign o_dot = w_p1 + w_p2 + w_p3;

endmodule

// File: rtl/dot_product_collector.sv
// Collects one dot product per in_valid cycle into a small result buffer, then
// streams the buffered results out in row-major order over a valid/ready port.
module dot_product_collector #(
  parameter int DW    = dot_product_collector_pkg::DW,
  parameter int RW    = dot_product_collector_pkg::RW,
  parameter int DEPTH = dot_product_collector_pkg::DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          start,
  input  logic [1:0]    row_w,
  input  logic [1:0]    col_x,
  input  logic          in_valid,
  input  logic [DW-1:0] in_w1,
  input  logic [DW-1:0] in_w2,
  input  logic [DW-1:0] in_w3,
  input  logic [DW-1:0] in_x1,
  input  logic [DW-1:0] in_x2,
  input  logic [DW-1:0] in_x3,
  output logic [RW-1:0] res_data,
  output logic [3:0]    res_idx,
  output logic          res_valid,
  input  logic          res_ready,
  output logic          busy,
  output logic          done,
  output logic          err
);

  import dot_product_collector_pkg::*;

  state_t        r_state;
  logic [3:0]    r_n;
  logic [3:0]    r_wr_ptr;
  logic [3:0]    r_rd_ptr;
  logic          r_res_valid;
  logic          r_busy;
  logic          r_done;
  logic          r_err;
  logic [RW-1:0] r_buf [DEPTH];

  logic [3:0]    w_n;
  logic [RW-1:0] w_dot;
  logic          w_wr_en;
  logic          w_last_wr;
  logic          w_last_rd;

  // Job size is an unsigned 2x2-bit product, 0..9.
  assign w_n       = {2'b00, row_w} * {2'b00, col_x};
  assign w_wr_en   = (r_state == CAPTURE) && in_valid;
  assign w_last_wr = (r_wr_ptr == (r_n - 4'd1));
  assign w_last_rd = (r_rd_ptr == (r_n - 4'd1));

  dot3_unit #(
    .DW (DW),
    .RW (RW)
  ) u_dot3 (
    .i_w1  (in_w1),
    .i_w2  (in_w2),
    .i_w3  (in_w3),
    .i_x1  (in_x1),
    .i_x2  (in_x2),
    .i_x3  (in_x3),
    .o_dot (w_dot)
  );

  // Result buffer: one entry written per captured lane set; wiped by reset so an
  // abandoned job leaves nothing behind.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_buf[i] <= '0;
      end
    end else if (w_wr_en) begin
      r_buf[r_wr_ptr] <= w_dot;
    end
  end

  // Job FSM with registered status flags; pointers stop at N-1 instead of wrapping.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_n         <= '0;
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_res_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_err <= 1'b0;
            r_n   <= w_n;
            if (w_n != 4'd0) begin
              r_state  <= CAPTURE;
              r_wr_ptr <= '0;
              r_rd_ptr <= '0;
              r_busy   <= 1'b1;
            end else begin
              r_state <= DONE;
              r_done  <= 1'b1;
            end
          end
        end
        CAPTURE: begin
          if (start) begin
            r_err <= 1'b1;
          end
          if (in_valid) begin
            if (w_last_wr) begin
              r_state     <= DRAIN;
              r_res_valid <= 1'b1;
            end else begin
              r_wr_ptr <= r_wr_ptr + 4'd1;
            end
          end
        end
        DRAIN: begin
          if (start || in_valid) begin
            r_err <= 1'b1;
          end
          if (res_ready) begin
            if (w_last_rd) begin
              r_state     <= DONE;
              r_res_valid <= 1'b0;
              r_busy      <= 1'b0;
              r_done      <= 1'b1;
            end else begin
              r_rd_ptr <= r_rd_ptr + 4'd1;
            end
          end
        end
        DONE: begin
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Data and index are forced to zero whenever no result is being offered.
  assign res_valid = r_res_valid;
  assign res_data  = r_res_valid ? r_buf[r_rd_ptr] : '0;
  assign res_idx   = r_res_valid ? r_rd_ptr : '0;
  assign busy      = r_busy;
  assign done      = r_done;
  assign err       = r_err;

endmodule

// File: tb/tb_dot_product_collector.sv
// Self-checking bench for dot_product_collector: directed scenarios plus random
// jobs, all compared against results computed here with plain arithmetic.
module tb_dot_product_collector;

  localparam int DW = 4;
  localparam int RW = 10;

  logic          clk       = 1'b0;
  logic          rst_n     = 1'b1;
  logic          start     = 1'b0;
  logic [1:0]    row_w     = '0;
  logic [1:0]    col_x     = '0;
  logic          in_valid  = 1'b0;
  logic [DW-1:0] in_w1     = '0;
  logic [DW-1:0] in_w2     = '0;
  logic [DW-1:0] in_w3     = '0;
  logic [DW-1:0] in_x1     = '0;
  logic [DW-1:0] in_x2     = '0;
  logic [DW-1:0] in_x3     = '0;
  logic [RW-1:0] res_data;
  logic [3:0]    res_idx;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          busy;
  logic          done;
  logic          err;

  int n_checks = 0;
  int n_errors = 0;

  // Lane operands for each element of the current job: [element][lane].
  int lw [9][3];
  int lx [9][3];

  always #5 clk = ~clk;

  dot_product_collector #(
    .DW    (DW),
    .RW    (RW),
    .DEPTH (9)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .row_w     (row_w),
    .col_x     (col_x),
    .in_valid  (in_valid),
    .in_w1     (in_w1),
    .in_w2     (in_w2),
    .in_w3     (in_w3),
    .in_x1     (in_x1),
    .in_x2     (in_x2),
    .in_x3     (in_x3),
    .res_data  (res_data),
    .res_idx   (res_idx),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %0d exp %0d", tag, got, exp);
    end
  endtask

  function automatic int model_dot(input int k);
    return lw[k][0] * lx[k][0] + lw[k][1] * lx[k][1] + lw[k][2] * lx[k][2];
  endfunction

  task automatic set_lanes(input int k);
    in_w1 = 4'(lw[k][0]);
    in_w2 = 4'(lw[k][1]);
    in_w3 = 4'(lw[k][2]);
    in_x1 = 4'(lx[k][0]);
    in_x2 = 4'(lx[k][1]);
    in_x3 = 4'(lx[k][2]);
  endtask

  task automatic clear_lanes();
    in_w1 = '0; in_w2 = '0; in_w3 = '0;
    in_x1 = '0; in_x2 = '0; in_x3 = '0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq({tag, "_data"},  int'(res_data),  0);
    check_eq({tag, "_idx"},   int'(res_idx),   0);
    check_eq({tag, "_valid"}, int'(res_valid), 0);
    check_eq({tag, "_busy"},  int'(busy),      0);
    check_eq({tag, "_done"},  int'(done),      0);
    check_eq({tag, "_err"},   int'(err),       0);
  endtask

  // Runs one complete job from start to done; called and returning at a negedge.
  task automatic run_job(input int rw, input int cx, input int bp_pct,
                         input int gap_pct, input int hold_idx);
    int n;
    int k;
    int cyc;
    int hold_left;
    int exp_q[$];
    n = rw * cx;
    for (int i = 0; i < n; i++) exp_q.push_back(model_dot(i));
    start = 1'b1;
    row_w = 2'(rw);
    col_x = 2'(cx);
    @(negedge clk);
    start = 1'b0;
    check_eq("err_clear_on_start", int'(err), 0);
    if (n == 0) begin
      check_eq("empty_done",  int'(done),      1);
      check_eq("empty_valid", int'(res_valid), 0);
      check_eq("empty_busy",  int'(busy),      0);
      @(negedge clk);
      check_eq("empty_done_end", int'(done), 0);
      check_eq("empty_busy_end", int'(busy), 0);
      $display("job %0dx%0d n=0 empty", rw, cx);
      return;
    end
    check_eq("cap_busy",  int'(busy),      1);
    check_eq("cap_valid", int'(res_valid), 0);
    for (int e = 0; e < n; e++) begin
      if ($urandom_range(0, 99) < gap_pct) begin
        in_valid = 1'b0;
        @(negedge clk);
        check_eq("gap_busy",  int'(busy),      1);
        check_eq("gap_valid", int'(res_valid), 0);
      end
      in_valid = 1'b1;
      set_lanes(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
    clear_lanes();
    check_eq("latency_valid", int'(res_valid), 1);
    k = 0;
    cyc = 0;
    hold_left = 3;
    while (k < n && cyc < 400) begin
      check_eq("drain_valid", int'(res_valid), 1);
      check_eq("drain_idx",   int'(res_idx),   k);
      check_eq("drain_data",  int'(res_data),  exp_q[k]);
      check_eq("drain_busy",  int'(busy),      1);
      if (k == hold_idx && hold_left > 0) begin
        res_ready = 1'b0;
        hold_left--;
      end else begin
        res_ready = ($urandom_range(0, 99) >= bp_pct);
      end
      @(negedge clk);
      cyc++;
      if (res_ready) k++;
    end
    res_ready = 1'b0;
    check_eq("drain_count", k, n);
    check_eq("done_pulse",  int'(done),      1);
    check_eq("done_valid",  int'(res_valid), 0);
    check_eq("done_busy",   int'(busy),      0);
    check_eq("done_err",    int'(err),       0);
    @(negedge clk);
    check_eq("done_end", int'(done), 0);
    $display("job %0dx%0d n=%0d drained in %0d cycles", rw, cx, n, cyc);
  endtask

  initial begin
    int rw;
    int cx;
    int e0;
    int e1;

    // Power-on reset.
    #1 rst_n = 1'b0;
    #1 check_all_zero("reset");
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset_hold");
    rst_n = 1'b1;

    // Single full-scale element, started on the first edge after reset release.
    for (int j = 0; j < 3; j++) begin
      lw[0][j] = 15;
      lx[0][j] = 15;
    end
    run_job(1, 1, 0, 0, -1);

    // 2x2 job with three cycles of backpressure at index 1.
    lw[0] = '{1, 2, 0}; lx[0] = '{5, 7, 0};
    lw[1] = '{1, 2, 0}; lx[1] = '{6, 8, 0};
    lw[2] = '{3, 4, 0}; lx[2] = '{5, 7, 0};
    lw[3] = '{3, 4, 0}; lx[3] = '{6, 8, 0};
    run_job(2, 2, 0, 0, 1);

    // Degenerate jobs.
    run_job(0, 2, 0, 0, -1);
    run_job(3, 0, 0, 0, -1);

    // in_valid while idle is ignored without raising err.
    in_valid = 1'b1;
    set_lanes(0);
    @(negedge clk);
    in_valid = 1'b0;
    clear_lanes();
    check_eq("idle_inval_err",   int'(err),       0);
    check_eq("idle_inval_valid", int'(res_valid), 0);
    check_eq("idle_inval_busy",  int'(busy),      0);

    // Protocol errors: start during CAPTURE, then in_valid during DRAIN.
    lw[0] = '{2, 3, 0}; lx[0] = '{4, 5, 0};
    lw[1] = '{1, 1, 1}; lx[1] = '{7, 7, 7};
    e0 = model_dot(0);
    e1 = model_dot(1);
    start = 1'b1; row_w = 2'd1; col_x = 2'd2;
    @(negedge clk);
    start = 1'b0;
    in_valid = 1'b1;
    set_lanes(0);
    @(negedge clk);
    in_valid = 1'b0;
    start = 1'b1; row_w = 2'd3; col_x = 2'd3;
    @(negedge clk);
    start = 1'b0;
    check_eq("start_busy_err",  int'(err),  1);
    check_eq("start_busy_busy", int'(busy), 1);
    in_valid = 1'b1;
    set_lanes(1);
    @(negedge clk);
    check_eq("perr_valid", int'(res_valid), 1);
    check_eq("perr_data0", int'(res_data),  e0);
    in_w1 = 4'hF; in_w2 = 4'hF; in_w3 = 4'hF;
    in_x1 = 4'hF; in_x2 = 4'hF; in_x3 = 4'hF;
    res_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    clear_lanes();
    check_eq("drain_inval_data", int'(res_data), e0);
    check_eq("drain_inval_idx",  int'(res_idx),  0);
    check_eq("drain_inval_err",  int'(err),      1);
    res_ready = 1'b1;
    @(negedge clk);
    check_eq("perr_idx1",  int'(res_idx),  1);
    check_eq("perr_data1", int'(res_data), e1);
    @(negedge clk);
    res_ready = 1'b0;
    check_eq("perr_done",       int'(done), 1);
    check_eq("perr_err_sticky", int'(err),  1);
    @(negedge clk);
    check_eq("perr_err_idle", int'(err), 1);
    $display("job 1x2 n=2 protocol errors injected");

    // Reset in the middle of DRAIN, then a fresh job.
    lw[0] = '{1, 2, 0}; lx[0] = '{5, 7, 0};
    lw[1] = '{1, 2, 0}; lx[1] = '{6, 8, 0};
    lw[2] = '{3, 4, 0}; lx[2] = '{5, 7, 0};
    lw[3] = '{3, 4, 0}; lx[3] = '{6, 8, 0};
    start = 1'b1; row_w = 2'd2; col_x = 2'd2;
    @(negedge clk);
    start = 1'b0;
    for (int e = 0; e < 4; e++) begin
      in_valid = 1'b1;
      set_lanes(e);
      @(negedge clk);
    end
    in_valid = 1'b0;
    clear_lanes();
    res_ready = 1'b1;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    res_ready = 1'b0;
    check_eq("mid_idx",  int'(res_idx), 1);
    check_eq("mid_err",  int'(err),     1);
    #2 rst_n = 1'b0;
    #1 check_all_zero("async_reset");
    @(negedge clk);
    check_all_zero("reset_mid_hold");
    rst_n = 1'b1;
    $display("job 2x2 n=4 abandoned by reset at idx 1");
    for (int j = 0; j < 3; j++) begin
      lw[0][j] = 15;
      lx[0][j] = 15;
    end
    run_job(1, 1, 0, 0, -1);

    // Random jobs with input gaps and random backpressure.
    for (int j = 0; j < 30; j++) begin
      rw = $urandom_range(0, 3);
      cx = $urandom_range(0, 3);
      for (int e = 0; e < 9; e++) begin
        for (int l = 0; l < 3; l++) begin
          lw[e][l] = ($urandom_range(0, 4) == 0) ? 0 : $urandom_range(0, 15);
          lx[e][l] = $urandom_range(0, 15);
        end
      end
      run_job(rw, cx, 30, 25, -1);
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
